// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in, serial-out serializer.
// The bit-order constants are also used by the receive-side shift_register bench.
package piso_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  localparam bit LsbFirst = 1'b0;
  localparam bit MsbFirst = 1'b1;

  // Counter width for a word of `width` bits; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-WIDTH bit index counter: clear has priority, enable advances and wraps after WIDTH-1.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LastIdx) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LastIdx);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with a valid/ready load and back-to-back words.
// Each accepted word appears on x over WIDTH cycles; done pulses the cycle after its last bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = LsbFirst
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             shifting;
  logic             accept;

  // The output end of the shift register holds the bit currently on x.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST == MsbFirst) ? w[WIDTH-1] : w[0];
  endfunction

  piso_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk  (clk),
    .n_rst(n_rst),
    .clr  (accept),
    .en   (shifting),
    .cnt  (cnt),
    .last (last)
  );

  assign shifting   = (state_q == StShift);
  assign load_ready = n_rst && ((state_q == StIdle) || last);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    x_valid_d = 1'b0;
    done_d    = shifting && last;
    if (accept) begin
      state_d   = StShift;
      shreg_d   = din;
      x_valid_d = 1'b1;
    end else if (shifting && !last) begin
      shreg_d   = (MSB_FIRST == MsbFirst) ? (shreg_q << 1) : (shreg_q >> 1);
      x_valid_d = 1'b1;
    end else if (shifting) begin
      state_d = StIdle;
      shreg_d = '0;
    end
    x_d = x_valid_d ? out_bit(shreg_d) : 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = shifting;
  assign done    = done_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (W4 LSB-first, W4 MSB-first, W8 LSB-first)
// checked against a bit-queue reference model by a negedge monitor.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic       lv   [3];
  logic [7:0] din  [3];
  logic       x    [3];
  logic       xv   [3];
  logic       busy [3];
  logic       done [3];
  logic       lr   [3];

  int unsigned widths [3] = '{4, 4, 8};
  bit          msbs   [3] = '{1'b0, 1'b1, 1'b0};

  // Expected serial stream per instance: bit0 = data bit, bit1 = last bit of its word.
  int  q    [3][$];
  bit  pend [3];
  int  checks = 0;
  int  errors = 0;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb4 (
    .clk(clk), .n_rst(n_rst), .load_valid(lv[0]), .load_ready(lr[0]), .din(din[0][3:0]),
    .x(x[0]), .x_valid(xv[0]), .busy(busy[0]), .done(done[0])
  );
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb4 (
    .clk(clk), .n_rst(n_rst), .load_valid(lv[1]), .load_ready(lr[1]), .din(din[1][3:0]),
    .x(x[1]), .x_valid(xv[1]), .busy(busy[1]), .done(done[1])
  );
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
    .clk(clk), .n_rst(n_rst), .load_valid(lv[2]), .load_ready(lr[2]), .din(din[2]),
    .x(x[2]), .x_valid(xv[2]), .busy(busy[2]), .done(done[2])
  );

  task automatic check(input string name, input int k, input logic [4:0] got,
                       input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got %b expected %b", name, k, $time, got, exp);
    end
  endtask

  // Reference: a word is taken whenever the model has nothing left to show.
  always @(posedge clk) begin
    if (n_rst) begin
      for (int k = 0; k < 3; k++) begin
        if (lv[k] === 1'b1 && q[k].size() == 0) begin
          for (int i = 0; i < int'(widths[k]); i++) begin
            int idx;
            idx = msbs[k] ? (int'(widths[k]) - 1 - i) : i;
            q[k].push_back(int'(din[k][idx]) | ((i == int'(widths[k]) - 1) ? 2 : 0));
          end
        end
      end
    end
  end

  always @(negedge n_rst) begin
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      pend[k] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!n_rst) begin
        check("reset_outputs", k, {x[k], xv[k], busy[k], done[k], lr[k]}, 5'b0);
      end else begin
        bit has;
        check("done", k, {4'b0, done[k]}, {4'b0, pend[k]});
        pend[k] = 1'b0;
        has = (q[k].size() != 0);
        check("x_valid", k, {4'b0, xv[k]}, {4'b0, has});
        check("busy", k, {4'b0, busy[k]}, {4'b0, has});
        if (has) begin
          int e;
          e = q[k].pop_front();
          check("x", k, {4'b0, x[k]}, {4'b0, e[0]});
          pend[k] = e[1];
        end else begin
          check("x_idle", k, {4'b0, x[k]}, 5'b0);
        end
        check("load_ready", k, {4'b0, lr[k]}, {4'b0, (q[k].size() == 0)});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] d4, input logic [7:0] d8);
    lv[0] = v; lv[1] = v; lv[2] = v;
    din[0] = d4; din[1] = d4; din[2] = d8;
  endtask

  initial begin
    drive(1'b0, 8'h00, 8'h00);
    #7 n_rst = 1'b1;
    cyc(2);
    // Single word.
    drive(1'b1, 8'h0B, 8'hA5); cyc(1);
    drive(1'b0, 8'h00, 8'h00); cyc(12);
    // Back to back: second word held on load_valid until taken.
    drive(1'b1, 8'h0B, 8'hA5); cyc(1);
    drive(1'b1, 8'h06, 8'h3C); cyc(8);
    drive(1'b0, 8'h00, 8'h00); cyc(20);
    // Load attempt mid-word must be ignored.
    drive(1'b1, 8'h0B, 8'hA5); cyc(1);
    drive(1'b1, 8'h00, 8'h00); cyc(1);
    drive(1'b0, 8'hFF, 8'hFF); cyc(12);
    // Reset during bit 2, then a fresh word.
    drive(1'b1, 8'h0B, 8'hA5); cyc(1);
    drive(1'b0, 8'h00, 8'h00); cyc(2);
    n_rst = 1'b0; cyc(2);
    n_rst = 1'b1; cyc(1);
    drive(1'b1, 8'h01, 8'h01); cyc(1);
    drive(1'b0, 8'h00, 8'h00); cyc(12);
    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        lv[k]  = ($urandom_range(0, 3) != 0);
        din[k] = 8'($urandom);
      end
      cyc(1);
    end
    drive(1'b0, 8'h00, 8'h00); cyc(12);
    for (int k = 0; k < 3; k++) begin
      check("drained", k, 5'(q[k].size()), 5'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out shift register with a load handshake. It is the transmit end of the team's serial-in shift_register, and its x output drives that block's x input one bit per clk. The block accepts a WIDTH-bit word, then emits it on x over WIDTH consecutive cycles. Words can be loaded back to back with no gap between them, and done flags the completion of each word.

Parameters:
WIDTH, 4, word length in bits; must be 2 or more.
MSB_FIRST, 0, bit order on x: 0 sends din[0] first, 1 sends din[WIDTH-1] first.

Ports:
clk  input  1  clock; all state updates on the rising edge.
n_rst  input  1  asynchronous active-low reset.
load_valid  input  1  a word is offered on din.
load_ready  output  1  the block can accept a word this cycle.
din  input  WIDTH  parallel word; sampled only on an accepting edge.
x  output  1  serial data, registered.
x_valid  output  1  x carries a valid bit this cycle, registered.
busy  output  1  state is SHIFT.
done  output  1  one-cycle pulse after the last bit of a word, registered.

Behaviour:
- Interface rule (already decided): one clock, clk. Reset is n_rst, asynchronous and active-low. Flops clear immediately when n_rst falls and hold clear while n_rst is low.
- Reset values:
  - state = IDLE, shreg = 0, cnt = 0.
  - x = 0, x_valid = 0, done = 0, busy = 0.
  - load_ready = 0 while n_rst is low (it is gated by n_rst).
- Registers:
  - shreg[WIDTH-1:0].
  - cnt[$clog2(WIDTH)-1:0]: index of the bit currently on x.
  - 2-state FSM: IDLE, SHIFT.
- load_ready = n_rst && (state==IDLE || (state==SHIFT && cnt==WIDTH-1)). It is combinational.
- Accept: a word is accepted on an edge where load_valid && load_ready. On that edge:
  - shreg <= din, cnt <= 0, state <= SHIFT.
  - x_valid <= 1.
  - x <= din[0], or din[WIDTH-1] if MSB_FIRST.
- Bit timing: bit i of the accepted word is on x during cycle i after the accepting edge (i = 0..WIDTH-1). First-bit latency is 1 edge.
- Each SHIFT edge with cnt < WIDTH-1:
  - cnt++.
  - shreg shifts toward the output end and fills with 0.
  - x takes the next bit; x_valid stays 1.
- Edge with cnt == WIDTH-1 (last bit on x):
  - done <= 1 for exactly one cycle.
  - If load_valid is high, the accept rule applies: the next word starts with no bubble, and state stays SHIFT.
  - Otherwise: state <= IDLE, x_valid <= 0, x <= 0, cnt <= 0.
- In IDLE, x is held at 0 and x_valid at 0.
- load_valid while load_ready is low (mid-word) is ignored. din is not sampled and the word in flight is not disturbed.
- done and a new acceptance may coincide: done refers to the previous word.
- Reset mid-word: the word is abandoned immediately with all outputs at their reset values. After n_rst rises, load_ready = 1 on the first cycle.
- din may change freely except on the accepting edge.
- Throughput: one word per WIDTH cycles.

Decomposition:
- Shared package piso_pkg:
  - state enum {IDLE, SHIFT}.
  - localparam CNT_W = $clog2(WIDTH).
  - The bit-order constants, shared with the receive-side shift_register bench.
- One natural sub-module, piso_bit_counter: a modulo-WIDTH counter with clear, enable and a last output (cnt==WIDTH-1). The top level holds the FSM, shreg and output registers.

Test Plan:
1. WIDTH=4, MSB_FIRST=0; release reset at 7; load 4'b1011 -> x = 1,1,0,1 on 4 consecutive cycles, x_valid high for exactly 4 cycles, done high on the 5th cycle only, back to IDLE with x=0.
2. Back to back: load 4'b1011, then 4'b0110 held on load_valid -> 8 contiguous valid bits 1,1,0,1,0,1,1,0, no x_valid gap, done pulses twice, load_ready high only on each cnt==3 cycle.
3. Ignored load: during bit 1 of 4'b1011, drive load_valid=1 with din=4'b0000 -> load_ready=0, x sequence unchanged 1,1,0,1, no extra word.
4. Reset mid-word: n_rst low during bit 2 of 4'b1011 -> x=0, x_valid=0, busy=0, done=0 immediately. After release, load_ready=1, and loading 4'b0001 gives 1,0,0,0.
5. MSB_FIRST=1, WIDTH=4; load 4'b1011 -> x = 1,0,1,1; done once.
6. WIDTH=8; load 8'hA5 -> x = 1,0,1,0,0,1,0,1 (LSB first), x_valid 8 cycles, done on the 9th.
